// File: rtl/brightness_sequencer.sv
// Multi-channel brightness ramp generator: sawtooth, triangle or hold ramps
// paced by a shared prescaler, with channel i starting i steps ahead of channel 0.
module brightness_sequencer #(
   parameter int N_CH     = 4,
   parameter int WIDTH    = 6,
   parameter int DIV      = 1,
   parameter int DEF_STEP = 5,
   parameter int DEF_MAX  = 50
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [WIDTH-1:0]      cfg_step,
   input  logic [WIDTH-1:0]      cfg_max,
   input  logic [1:0]            cfg_mode,
   output logic [N_CH*WIDTH-1:0] brightness,
   output logic                  wrap
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW = WIDTH + ((N_CH > 1) ? $clog2(N_CH) : 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [1:0] MODE_SAW = 2'd0;
   localparam logic [1:0] MODE_TRI = 2'd1;

   typedef enum logic {S_IDLE, S_APPLY} state_t;
   state_t state_q, state_d;

   logic [WIDTH-1:0] step_q, max_q;
   logic [1:0]       mode_q;
   logic [CW-1:0]    cnt_q;
   logic [N_CH-1:0]  dir_down_q, dir_down_d;
   logic [WIDTH-1:0] val_q [N_CH];
   logic [WIDTH-1:0] val_d [N_CH];
   logic             cfg_fire, tick, wrap_d;

   // start(i) = min(i*step, max), product kept wide enough not to overflow.
   function automatic logic [WIDTH-1:0] start_val(input int idx,
                                                   input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] m);
      logic [PW-1:0] prod;
      prod = PW'(idx) * PW'(s);
      start_val = (prod > PW'(m)) ? m : prod[WIDTH-1:0];
   endfunction

   // Returns {direction_down, next_value} for one channel on a tick.
   function automatic logic [WIDTH:0] ch_next(input logic [WIDTH-1:0] cur,
                                              input logic             down,
                                              input logic [WIDTH-1:0] s,
                                              input logic [WIDTH-1:0] m,
                                              input logic [1:0]       md);
      logic [WIDTH:0]   sum;
      logic [WIDTH-1:0] up_val, dn_val;
      sum     = {1'b0, cur} + {1'b0, s};
      up_val  = (sum > {1'b0, m}) ? m : sum[WIDTH-1:0];
      dn_val  = (cur > s) ? cur - s : {WIDTH{1'b0}};
      ch_next = {down, cur};
      if (s != '0) begin
         if (md == MODE_SAW) begin
            ch_next = {down, (cur >= m) ? {WIDTH{1'b0}} : up_val};
         end else if (md == MODE_TRI) begin
            if (!down)
               ch_next = (cur >= m) ? {1'b1, dn_val} : {1'b0, up_val};
            else
               ch_next = (cur == '0) ? {1'b0, up_val} : {1'b1, dn_val};
         end
      end
   endfunction

   // Handshake: a config transfer happens on any rising edge where cfg_valid
   // and cfg_ready are both high; cfg_ready is low only during the apply cycle.
   always_comb begin
      state_d   = state_q;
      cfg_ready = (state_q == S_IDLE);
      cfg_fire  = cfg_valid && cfg_ready;
      case (state_q)
         S_IDLE:  if (cfg_fire) state_d = S_APPLY;
         S_APPLY: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tick       = en && (cnt_q == CNT_LAST) && (state_q == S_IDLE);
      dir_down_d = dir_down_q;
      for (int i = 0; i < N_CH; i++) begin
         {dir_down_d[i], val_d[i]} = ch_next(val_q[i], dir_down_q[i], step_q, max_q, mode_q);
      end
      wrap_d = tick && (val_q[0] != '0) && (val_d[0] == '0);
   end

   always_comb begin
      brightness = '0;
      for (int i = 0; i < N_CH; i++) brightness[i*WIDTH +: WIDTH] = val_q[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         step_q     <= WIDTH'(DEF_STEP);
         max_q      <= WIDTH'(DEF_MAX);
         mode_q     <= MODE_SAW;
         cnt_q      <= '0;
         wrap       <= 1'b0;
         dir_down_q <= '0;
         for (int i = 0; i < N_CH; i++)
            val_q[i] <= start_val(i, WIDTH'(DEF_STEP), WIDTH'(DEF_MAX));
      end else begin
         state_q <= state_d;
         if (cfg_fire) begin
            step_q <= cfg_step;
            max_q  <= cfg_max;
            mode_q <= cfg_mode;
         end
         if (state_q == S_APPLY) begin
            // Restart from the config latched on the previous edge.
            cnt_q      <= '0;
            wrap       <= 1'b0;
            dir_down_q <= '0;
            for (int i = 0; i < N_CH; i++)
               val_q[i] <= start_val(i, step_q, max_q);
         end else begin
            if (en) cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            wrap <= wrap_d;
            if (tick) begin
               dir_down_q <= dir_down_d;
               for (int i = 0; i < N_CH; i++) val_q[i] <= val_d[i];
            end
         end
      end
   end
endmodule

// File: tb/tb_brightness_sequencer.sv
// Bench for brightness_sequencer: vector table, hand-written ramp sequences,
// and randomized traffic compared against an integer reference model.
module tb_brightness_sequencer;
   localparam int N_CH     = 4;
   localparam int WIDTH    = 6;
   localparam int BW       = N_CH * WIDTH;
   localparam int DEF_STEP = 5;
   localparam int DEF_MAX  = 50;

   logic             clk, rst, en, cfg_valid;
   logic [WIDTH-1:0] cfg_step, cfg_max;
   logic [1:0]       cfg_mode;
   logic             cfg_ready, wrap, ready4, wrap4;
   logic [BW-1:0]    brightness, bright4;

   int n_tests = 0;
   int n_fail  = 0;
   logic [BW-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   brightness_sequencer #(.N_CH(N_CH), .WIDTH(WIDTH), .DIV(1),
                          .DEF_STEP(DEF_STEP), .DEF_MAX(DEF_MAX)) dut (
      .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_step(cfg_step), .cfg_max(cfg_max), .cfg_mode(cfg_mode),
      .brightness(brightness), .wrap(wrap));

   brightness_sequencer #(.N_CH(N_CH), .WIDTH(WIDTH), .DIV(4),
                          .DEF_STEP(DEF_STEP), .DEF_MAX(DEF_MAX)) dut4 (
      .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(ready4),
      .cfg_step(cfg_step), .cfg_max(cfg_max), .cfg_mode(cfg_mode),
      .brightness(bright4), .wrap(wrap4));

   // ---------------- reference model (DIV = 1 instance) ----------------
   int m_step, m_max, m_mode, m_cnt, m_apply, m_wrap;
   int m_val[N_CH];
   int m_down[N_CH];

   function automatic int start_of(input int i, input int s, input int mx);
      return (i * s > mx) ? mx : i * s;
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int floor0(input int a);
      return (a < 0) ? 0 : a;
   endfunction

   task automatic model_step();
      int fire, tick, old0, v;
      if (rst) begin
         m_step = DEF_STEP; m_max = DEF_MAX; m_mode = 0;
         m_cnt = 0; m_apply = 0; m_wrap = 0;
         for (int i = 0; i < N_CH; i++) begin
            m_val[i]  = start_of(i, DEF_STEP, DEF_MAX);
            m_down[i] = 0;
         end
         return;
      end
      fire = (cfg_valid && !m_apply) ? 1 : 0;
      if (m_apply != 0) begin
         for (int i = 0; i < N_CH; i++) begin
            m_val[i]  = start_of(i, m_step, m_max);
            m_down[i] = 0;
         end
         m_cnt = 0; m_wrap = 0; m_apply = 0;
      end else begin
         tick = (en && m_cnt == 0) ? 1 : 0;
         if (en) m_cnt = 0;
         old0 = m_val[0];
         if (tick != 0 && m_step != 0 && m_mode < 2) begin
            for (int i = 0; i < N_CH; i++) begin
               v = m_val[i];
               if (m_mode == 0) begin
                  v = (v >= m_max) ? 0 : imin(v + m_step, m_max);
               end else if (m_down[i] == 0) begin
                  if (v >= m_max) begin m_down[i] = 1; v = floor0(v - m_step); end
                  else v = imin(v + m_step, m_max);
               end else begin
                  if (v == 0) begin m_down[i] = 0; v = imin(m_step, m_max); end
                  else v = floor0(v - m_step);
               end
               m_val[i] = v;
            end
         end
         m_wrap = (tick != 0 && old0 != 0 && m_val[0] == 0) ? 1 : 0;
      end
      if (fire != 0) begin
         m_step = cfg_step; m_max = cfg_max; m_mode = cfg_mode; m_apply = 1;
      end
   endtask

   function automatic logic [BW-1:0] model_pack();
      logic [BW-1:0] p;
      p = '0;
      for (int i = 0; i < N_CH; i++) p[i*WIDTH +: WIDTH] = WIDTH'(m_val[i]);
      return p;
   endfunction

   function automatic logic [BW-1:0] pk(input int c0, input int c1, input int c2, input int c3);
      return {WIDTH'(c3), WIDTH'(c2), WIDTH'(c1), WIDTH'(c0)};
   endfunction

   // ---------------- driver / checker tasks ----------------
   task automatic step_clk();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic v,
                        input int s, input int mx, input int md);
      rst = r; en = e; cfg_valid = v;
      cfg_step = WIDTH'(s); cfg_max = WIDTH'(mx); cfg_mode = 2'(md);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          rst, en, valid;
      int            step, max, mode;
      logic [BW-1:0] exp_b;
      logic          exp_wrap, exp_ready;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic r, input logic e, input logic v, input int s, input int mx,
                      input int md, input logic [BW-1:0] b, input logic w, input logic rdy);
      vec_t t;
      t.rst = r; t.en = e; t.valid = v; t.step = s; t.max = mx; t.mode = md;
      t.exp_b = b; t.exp_wrap = w; t.exp_ready = rdy;
      vecs.push_back(t);
   endtask

   initial begin
      int n_en, exp0, wraps;
      logic [BW-1:0] hold_vals;
      drive(1, 0, 0, 0, 0, 0);

      // reset, default ramp, en freeze, sawtooth step 7 max 20
      add(1, 0, 0, 0, 0, 0, pk(0, 5, 10, 15),   0, 1);
      add(0, 1, 0, 0, 0, 0, pk(5, 10, 15, 20),  0, 1);
      add(0, 1, 0, 0, 0, 0, pk(10, 15, 20, 25), 0, 1);
      add(0, 0, 0, 0, 0, 0, pk(10, 15, 20, 25), 0, 1);
      add(0, 1, 1, 7, 20, 0, pk(15, 20, 25, 30), 0, 0);
      add(0, 1, 0, 0, 0, 0, pk(0, 7, 14, 20),   0, 1);
      add(0, 1, 0, 0, 0, 0, pk(7, 14, 20, 0),   0, 1);
      add(0, 1, 0, 0, 0, 0, pk(14, 20, 0, 7),   0, 1);
      add(0, 1, 0, 0, 0, 0, pk(20, 0, 7, 14),   0, 1);
      add(0, 1, 0, 0, 0, 0, pk(0, 7, 14, 20),   1, 1);
      add(0, 1, 0, 0, 0, 0, pk(7, 14, 20, 0),   0, 1);
      // reset wins over a concurrent config offer
      add(1, 1, 1, 3, 50, 0, pk(0, 5, 10, 15),  0, 1);
      add(0, 1, 0, 0, 0, 0, pk(5, 10, 15, 20),  0, 1);
      // triangle step 5 max 12
      add(0, 1, 1, 5, 12, 1, pk(10, 15, 20, 25), 0, 0);
      add(0, 1, 0, 0, 0, 0, pk(0, 5, 10, 12),   0, 1);
      add(0, 1, 0, 0, 0, 0, pk(5, 10, 12, 7),   0, 1);
      add(0, 1, 0, 0, 0, 0, pk(10, 12, 7, 2),   0, 1);
      add(0, 1, 0, 0, 0, 0, pk(12, 7, 2, 0),    0, 1);
      add(0, 1, 0, 0, 0, 0, pk(7, 2, 0, 5),     0, 1);
      add(0, 1, 0, 0, 0, 0, pk(2, 0, 5, 10),    0, 1);
      add(0, 1, 0, 0, 0, 0, pk(0, 5, 10, 12),   1, 1);
      add(0, 1, 0, 0, 0, 0, pk(5, 10, 12, 7),   0, 1);

      foreach (vecs[k]) begin
         drive(vecs[k].rst, vecs[k].en, vecs[k].valid, vecs[k].step, vecs[k].max, vecs[k].mode);
         step_clk();
         check($sformatf("vec%0d_bright", k), brightness, vecs[k].exp_b);
         check($sformatf("vec%0d_wrap", k), BW'(wrap), BW'(vecs[k].exp_wrap));
         check($sformatf("vec%0d_ready", k), BW'(cfg_ready), BW'(vecs[k].exp_ready));
      end

      // default sawtooth: channel 0 walks 0,5,..,50,0 and wraps once per 11 cycles
      drive(1, 1, 0, 0, 0, 0);
      step_clk();
      check("saw_start", brightness, pk(0, 5, 10, 15));
      drive(0, 1, 0, 0, 0, 0);
      wraps = 0;
      for (int k = 1; k <= 33; k++) begin
         step_clk();
         exp0 = 5 * (k % 11);
         if (wrap) wraps++;
         check($sformatf("saw_ch0_k%0d", k), BW'(brightness[WIDTH-1:0]), BW'(exp0));
         check($sformatf("saw_wrap_k%0d", k), BW'(wrap), BW'(k % 11 == 0));
      end
      check("saw_wrap_count", BW'(wraps), BW'(3));

      // hold mode: values frozen at start values, cfg_ready low for one cycle only
      drive(0, 1, 1, 5, 50, 2);
      step_clk();
      check("hold_ready_drop", BW'(cfg_ready), BW'(0));
      drive(0, 1, 0, 0, 0, 0);
      step_clk();
      check("hold_ready_back", BW'(cfg_ready), BW'(1));
      hold_vals = pk(0, 5, 10, 15);
      check("hold_start", brightness, hold_vals);
      for (int k = 0; k < 50; k++) begin
         step_clk();
         check($sformatf("hold_val_%0d", k), brightness, hold_vals);
         check($sformatf("hold_wrap_%0d", k), BW'(wrap), BW'(0));
         check($sformatf("hold_ready_%0d", k), BW'(cfg_ready), BW'(1));
      end

      // DIV=4 instance: one step per 4 enabled cycles; en low stalls the prescaler
      drive(1, 0, 0, 0, 0, 0);
      step_clk();
      check("div4_reset_ch0", BW'(bright4[WIDTH-1:0]), BW'(0));
      check("div4_reset_ready", BW'(ready4), BW'(1));
      n_en = 0;
      for (int k = 1; k <= 20; k++) begin
         drive(0, !(k >= 9 && k <= 11), 0, 0, 0, 0);
         step_clk();
         if (en) n_en++;
         check($sformatf("div4_ch0_k%0d", k), BW'(bright4[WIDTH-1:0]), BW'(5 * (n_en / 4)));
         check($sformatf("div4_wrap_k%0d", k), BW'(wrap4), BW'(0));
      end

      // randomized traffic against the reference model
      drive(1, 1, 0, 0, 0, 0);
      step_clk();
      for (int k = 0; k < 3000; k++) begin
         rst       = ($urandom_range(0, 299) == 0);
         en        = ($urandom_range(0, 7) != 0);
         cfg_valid = ($urandom_range(0, 19) == 0);
         cfg_step  = ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom_range(1, 63));
         cfg_max   = ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom_range(1, 63));
         cfg_mode  = 2'($urandom_range(0, 3));
         step_clk();
         exp_q.push_back(model_pack());
         check("rand_bright", brightness, exp_q.pop_front());
         check("rand_wrap", BW'(wrap), BW'(m_wrap));
         check("rand_ready", BW'(cfg_ready), BW'(m_apply == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/brightness_sequencer.md
Name: brightness_sequencer

Overview:
Parametrised multi-channel brightness ramp generator for the LED/display dimming path. Each channel steps a brightness value by a runtime step up to a runtime ceiling, in sawtooth, triangle or hold mode, paced by an internal prescaler. Channels are phase-staggered by one step each. Configuration is loaded through a valid/ready handshake and restarts all channels.

Parameters:
N_CH, 4, number of brightness channels
WIDTH, 6, bits per brightness value
DIV, 1, clock cycles per ramp tick (1 = tick every enabled cycle)
DEF_STEP, 5, step value after reset
DEF_MAX, 50, ceiling value after reset

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
en  in  1  run enable; low freezes the prescaler and all channels
cfg_valid  in  1  config offer
cfg_ready  out  1  config accept; a transfer occurs when cfg_valid and cfg_ready are both high at a clock edge
cfg_step  in  WIDTH  new step
cfg_max  in  WIDTH  new ceiling
cfg_mode  in  2  0 = sawtooth, 1 = triangle, 2 and 3 = hold
brightness  out  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
wrap  out  1  one-cycle pulse when channel 0 returns to 0

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - step = DEF_STEP, max = DEF_MAX, mode = sawtooth.
  - Prescaler = 0.
  - Channel i = start(i), all channel directions up.
  - wrap = 0, cfg_ready = 1.
  - Reset takes priority over a concurrent cfg transfer and over tick.
- start(i) = min(i*step, max). The product is computed at WIDTH+clog2(N_CH) bits, then clamped.
- Prescaler:
  - Counts 0..DIV-1 while en = 1.
  - tick is asserted in the cycle the count is DIV-1, and the count wraps to 0.
  - en = 0 holds the count and suppresses tick.
- On each tick, per channel, with cur = current value:
  - Sawtooth:
    - If cur >= max, next = 0.
    - Else if cur+step > max, next = max.
    - Else next = cur+step.
  - Triangle, direction up:
    - If cur >= max, direction goes down and next = cur-step, floored at 0.
    - Else next = min(cur+step, max).
  - Triangle, direction down:
    - If cur == 0, direction goes up and next = min(step, max).
    - Else next = cur-step, floored at 0.
  - Hold: next = cur.
  - step = 0: values never change in any mode, and wrap never fires.
  - All sums are computed at WIDTH+1 bits. The output never exceeds max and never wraps modulo 2^WIDTH.
- Registered update: brightness changes on the clock edge at which tick is high, i.e. 1 cycle of latency from tick.
- wrap:
  - Asserted for exactly 1 cycle, registered alongside the update in which channel 0 goes from nonzero to 0 (sawtooth wrap, or triangle reaching the floor).
  - Not asserted on reset, on config restart, or in hold mode.
- Config transfer:
  - On a transfer edge, the cfg_* values are latched.
  - On the next edge, every channel is loaded with start(i) computed from the new step and max, directions are set up, and the prescaler is cleared.
  - cfg_ready is 0 for that one apply cycle and 1 otherwise.
  - Ticks are suppressed during the apply cycle.
- cfg_max = 0: all channels are forced to 0 and stay at 0.
- If cfg_max exceeds 2^WIDTH-1, that cannot occur by port width.
- A change of mode alone also goes through the restart.

Test Plan:
- Default config, DIV=1, en=1, channel 0:
  - Required sequence 0,5,10,…,50,0; wrap pulses once per 11 cycles.
  - Channels 1..3 start at 5,10,15.
- DIV=4:
  - Channel 0 advances by 5 every 4th cycle.
  - Dropping en for 3 cycles delays the next step by exactly 3 cycles.
- Config step=7, max=20, sawtooth:
  - After the restart, channel 0 reads 0,7,14,20,0.
  - Channel 2 starts at 14, channel 3 starts at 20.
- Triangle, step=5, max=12, channel 0:
  - Required sequence 0,5,10,12,7,2,0,5.
  - wrap is asserted in the cycle 0 appears after 2.
- Hold mode:
  - Values stay at their start values for 50 cycles.
  - wrap stays at 0.
  - cfg_ready drops for exactly 1 cycle after the transfer.
- Reset mid-ramp:
  - Assert rst in the same cycle as cfg_valid with step=3.
  - Required: next cycle shows default start values 0,5,10,15, cfg_ready=1, and the config is not applied.
